gol_sequencer: RTL and testbench
================================

# gol_sequencer

Generation sequencer for the Game-of-Life board held in the `current_state` row register file (WIDTH-bit rows, 2**REGBITS rows). On request it computes one full next generation in place by sweeping the rows once. It keeps a three-row sliding window so that original neighbour values survive overwrite. When not sweeping, it hands the register file's read port to an external display reader.

## Interface
Parameters:
- `WIDTH`, 8, cells per row (bit 0 = leftmost column).
- `REGBITS`, 3, row address width; `ROWS` = 2**REGBITS.
- `GENBITS`, 16, generation counter width.

Ports:
- `ph2`  in  1  single clock; all flops update on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one generation; sampled in IDLE only.
- `run`  in  1  level; chain generations back-to-back until deasserted or stable.
- `disp_ra`  in  REGBITS  display read address, honoured when not busy.
- `rd`  in  WIDTH  register file combinational read data.
- `ra`  out  REGBITS  register file read address.
- `wa`  out  REGBITS  register file write address.
- `wd`  out  WIDTH  register file write data.
- `regwrite`  out  1  register file write enable.
- `busy`  out  1  high in LOAD and SCAN.
- `done`  out  1  one-cycle pulse in DONE.
- `stable`  out  1  last completed generation changed no cell.
- `gen_count`  out  GENBITS  completed generations, wraps modulo 2**GENBITS.

## Operation
- States: IDLE, LOAD, SCAN, DONE.
- IDLE: `ra`=`disp_ra`; `regwrite`=0. If `start`, go to LOAD.
- LOAD: `ra`=0. Set `cur`<=`rd` and `prev`<=0, clear the change flag and set `row`<=0, then go to SCAN.
- SCAN (row i):
  - `ra`=i+1, or don't-care when i=ROWS-1.
  - `below` = `rd`, or 0 when i=ROWS-1.
  - `wd` = rule(`prev`, `cur`, `below`), `wa`=i, `regwrite`=1.
  - On the edge: `prev`<=`cur`, `cur`<=`below`, and set the change flag if `wd`≠`cur`.
  - After i=ROWS-1, go to DONE; otherwise i<=i+1.
- Rule, per bit j: count the 8 neighbours from `prev`/`cur`/`below` at columns j-1..j+1. Columns outside 0..WIDTH-1 and rows outside the board are dead (no wrap). Live when count==3, or when count==2 and the cell is live. Count width is 4 bits, with no overflow.
- DONE: `done`=1, `gen_count`+=1, `stable`<=!change flag.
  - If `run` and not (new `stable`), go to LOAD.
  - Otherwise go to IDLE.
- A write to row i and a read of row i+1 happen in the same cycle. The register file's read is combinational, so the write does not corrupt the read.
- `start` is ignored in LOAD, SCAN and DONE.

## Timing
- Reset, applied asynchronously: state=IDLE, `regwrite`=0, `busy`=0, `done`=0, `stable`=0, `gen_count`=0, window registers=0.
  - `ra` follows `disp_ra`; `wa`=0, `wd`=0.
- `start` sampled at edge E0:
  - LOAD follows E0.
  - SCAN rows 0..ROWS-1 follow E1..E_ROWS.
  - DONE follows E_(ROWS+1).
  - With ROWS=8, `done` is high in the cycle after the 9th edge following E0.
- Throughput:
  - Single-step mode: ROWS+3 cycles per generation, counting IDLE.
  - With `run` held: ROWS+2 cycles per generation.
- `regwrite` is high for exactly ROWS consecutive cycles per generation.
- Reset mid-SCAN: outputs drop immediately. Rows already written stay updated; the board is not restored.
- `run` is checked only in DONE. Deasserting it mid-sweep completes the current generation.

## Structure
- Shared package `gol_pkg`:
  - state enum `gol_state_t`;
  - `WIDTH`, `REGBITS`, `ROWS` defaults;
  - the neighbour-count width constant.
- Sub-module `gol_row_rule`: purely combinational, inputs `prev`/`cur`/`below`, output next row. It is reused by any future parallel-row engine.
- The FSM, window registers, counter and port mux live in `gol_sequencer`.

## Test plan
- **Blinker.** Row3=00011100, others 0; pulse `start`.
  - Expect rows 2, 3, 4 = 00001000 and the rest 0.
  - `done` after 9 edges, `gen_count`=1, `stable`=0.
  - A second `start` returns the original board.
- **Block.** Rows 1, 2 = 00011000; pulse `start`.
  - Board unchanged, `stable`=1.
  - With `run`=1, the sequencer returns to IDLE after one generation.
- **Edge boundary.** Row7=11100000 only.
  - Expect row6=01000000, row7=01000000, others 0. No wrap into row 0 or column 0.
- **Run mode.** Blinker with `run`=1 for 3 generations.
  - `done` pulses spaced 10 cycles apart, `gen_count`=3.
- **Port sharing.** In IDLE with `disp_ra`=5, expect `ra`=5 and `regwrite`=0.
  - During SCAN, `ra` ignores `disp_ra`.
  - `start` pulsed during SCAN has no effect.
- **Reset mid-op.** Drive `reset_n`=0 during the SCAN row-3 cycle.
  - `busy`, `regwrite`, `done` and `gen_count` go to 0 before the next edge; state=IDLE.
  - After reset is released, `start` runs a full generation normally.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types and defaults for the Game-of-Life generation sequencer.
package gol_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_REGBITS = 3;
    localparam int unsigned DEF_ROWS    = 1 << DEF_REGBITS;
    localparam int unsigned DEF_GENBITS = 16;

    // Eight neighbours fit in four bits with no overflow.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_DONE
    } gol_state_t;

endpackage

// File: rtl/gol_row_rule.sv
// Combinational Game-of-Life rule for one row.
// Ports: prev/cur/below - the row above, the row itself and the row below
//        (bit 0 = leftmost column); next_row - next-generation value of cur.
// Cells outside the row are dead; there is no wrap-around.
module gol_row_rule
    import gol_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] below,
    output logic [WIDTH-1:0] next_row
);

    // Dead padding column on each side; padded index j+1 is column j.
    logic [WIDTH+1:0] pp;
    logic [WIDTH+1:0] cp;
    logic [WIDTH+1:0] bp;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        pp       = {1'b0, prev, 1'b0};
        cp       = {1'b0, cur, 1'b0};
        bp       = {1'b0, below, 1'b0};
        cnt      = '0;
        next_row = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            cnt = CNT_W'(pp[j]) + CNT_W'(pp[j+1]) + CNT_W'(pp[j+2])
                + CNT_W'(cp[j])                   + CNT_W'(cp[j+2])
                + CNT_W'(bp[j]) + CNT_W'(bp[j+1]) + CNT_W'(bp[j+2]);
            next_row[j] = (cnt == CNT_W'(3)) || ((cnt == CNT_W'(2)) && cur[j]);
        end
    end

endmodule

// File: rtl/gol_sequencer.sv
// Sweeps the row register file once per generation, rewriting each row in
// place while a three-row window keeps the original neighbour values.
// Ports: ph2/reset_n clock and async active-low reset; start/run requests;
//        disp_ra display read address (used when idle); rd/ra/wa/wd/regwrite
//        register file access; busy/done/stable/gen_count status.
module gol_sequencer
    import gol_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned REGBITS = DEF_REGBITS,
    parameter int unsigned GENBITS = DEF_GENBITS
) (
    input  logic               ph2,
    input  logic               reset_n,
    input  logic               start,
    input  logic               run,
    input  logic [REGBITS-1:0] disp_ra,
    input  logic [WIDTH-1:0]   rd,
    output logic [REGBITS-1:0] ra,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    output logic               regwrite,
    output logic               busy,
    output logic               done,
    output logic               stable,
    output logic [GENBITS-1:0] gen_count
);

    localparam int unsigned        ROWS     = 1 << REGBITS;
    localparam logic [REGBITS-1:0] LAST_ROW = REGBITS'(ROWS - 1);

    gol_state_t         state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic [REGBITS-1:0] row_q, row_d;
    logic               chg_q, chg_d;
    logic               stable_q, stable_d;
    logic [GENBITS-1:0] gen_q, gen_d;
    logic               last_row;
    logic [WIDTH-1:0]   below;
    logic [WIDTH-1:0]   next_row;

    assign last_row  = (row_q == LAST_ROW);
    // Nothing lives below the bottom row.
    assign below     = last_row ? '0 : rd;
    assign stable    = stable_q;
    assign gen_count = gen_q;

    gol_row_rule #(
        .WIDTH(WIDTH)
    ) u_rule (
        .prev    (prev_q),
        .cur     (cur_q),
        .below   (below),
        .next_row(next_row)
    );

    // State and window registers.
    always_ff @(posedge ph2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            cur_q    <= '0;
            row_q    <= '0;
            chg_q    <= 1'b0;
            stable_q <= 1'b0;
            gen_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            cur_q    <= cur_d;
            row_q    <= row_d;
            chg_q    <= chg_d;
            stable_q <= stable_d;
            gen_q    <= gen_d;
        end
    end

    // Next-state, window update and register file port mux.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        cur_d    = cur_q;
        row_d    = row_q;
        chg_d    = chg_q;
        stable_d = stable_q;
        gen_d    = gen_q;
        ra       = disp_ra;
        wa       = '0;
        wd       = '0;
        regwrite = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                busy    = 1'b1;
                ra      = '0;
                cur_d   = rd;
                prev_d  = '0;
                chg_d   = 1'b0;
                row_d   = '0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                busy     = 1'b1;
                // Fetch row i+1 while row i is overwritten; the wrapped
                // address on the last row is masked off via below.
                ra       = REGBITS'(row_q + REGBITS'(1));
                wa       = row_q;
                wd       = next_row;
                regwrite = 1'b1;
                prev_d   = cur_q;
                cur_d    = below;
                if (next_row != cur_q) chg_d = 1'b1;
                if (last_row) state_d = ST_DONE;
                else          row_d   = REGBITS'(row_q + REGBITS'(1));
            end
            ST_DONE: begin
                done     = 1'b1;
                gen_d    = GENBITS'(gen_q + GENBITS'(1));
                stable_d = !chg_q;
                state_d  = (run && chg_q) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gol_sequencer.sv
// Randomized self-checking bench for gol_sequencer with a behavioural
// Game-of-Life board model and a register file model around the DUT.
module tb_gol_sequencer;

    localparam int ROWS  = 8;
    localparam int WIDTH = 8;

    logic       ph2;
    logic       reset_n;
    logic       start;
    logic       run;
    logic [2:0] disp_ra;
    logic [7:0] rd;
    logic [2:0] ra;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       regwrite;
    logic       busy;
    logic       done;
    logic       stable;
    logic [15:0] gen_count;

    // Register file: combinational read, write on the clock edge.
    logic [7:0] mem [ROWS];
    logic       tb_we;
    logic [2:0] tb_wa;
    logic [7:0] tb_wd;

    assign rd = mem[ra];

    always @(posedge ph2) begin
        if (regwrite)   mem[wa]    <= wd;
        else if (tb_we) mem[tb_wa] <= tb_wd;
    end

    gol_sequencer dut (
        .ph2      (ph2),
        .reset_n  (reset_n),
        .start    (start),
        .run      (run),
        .disp_ra  (disp_ra),
        .rd       (rd),
        .ra       (ra),
        .wa       (wa),
        .wd       (wd),
        .regwrite (regwrite),
        .busy     (busy),
        .done     (done),
        .stable   (stable),
        .gen_count(gen_count)
    );

    initial ph2 = 1'b0;
    always #5 ph2 = ~ph2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [7:0]  ref_b [ROWS];
    logic [7:0]  nxt_b [ROWS];
    bit          nxt_chg;
    bit          ref_stable;
    logic [15:0] ref_gen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph2);
        #1;
    endtask

    // Next generation of ref_b by direct neighbour counting.
    task automatic compute_next();
        int cnt, rr, cc;
        nxt_chg = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < WIDTH)
                            cnt += int'(ref_b[rr][cc]);
                    end
                end
                nxt_b[r][c] = (cnt == 3) || (cnt == 2 && ref_b[r][c] == 1'b1);
                if (nxt_b[r][c] != ref_b[r][c]) nxt_chg = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        compute_next();
        for (int r = 0; r < ROWS; r++) ref_b[r] = nxt_b[r];
        ref_stable = !nxt_chg;
        ref_gen    = ref_gen + 16'd1;
    endtask

    task automatic load_from_ref();
        for (int r = 0; r < ROWS; r++) begin
            tb_we = 1'b1;
            tb_wa = 3'(r);
            tb_wd = ref_b[r];
            tick();
        end
        tb_we = 1'b0;
    endtask

    task automatic clear_ref();
        for (int r = 0; r < ROWS; r++) ref_b[r] = 8'h00;
    endtask

    task automatic check_board();
        for (int r = 0; r < ROWS; r++)
            check($sformatf("row%0d", r), 32'(mem[r]), 32'(ref_b[r]));
    endtask

    // Start one generation (or a run-mode chain) and follow it to IDLE.
    task automatic do_gens(input int max_gens, input bit use_run, input bit poke);
        int cyc, gens, wr, last;
        bit more;
        run   = use_run;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; gens = 0; wr = 0; last = 0;
        check("busy_load", 32'(busy), 32'd1);
        while (1) begin
            tick();
            cyc++;
            if (poke && cyc == 4) start = 1'b1;
            if (poke && cyc == 5) start = 1'b0;
            if (gens == 0 && cyc == 3) check("ra_scan", 32'(ra), 32'd3);
            if (regwrite) wr++;
            if (cyc - last > 3 * ROWS) begin
                check("done_timeout", 32'd0, 32'd1);
                break;
            end
            if (done) begin
                gens++;
                model_step();
                check("done_gap", 32'(cyc - last), (gens == 1) ? 32'(ROWS + 1) : 32'(ROWS + 2));
                check("wr_cycles", 32'(wr), 32'(ROWS));
                wr   = 0;
                last = cyc;
                more = use_run && !ref_stable && gens < max_gens;
                if (!more) run = 1'b0;
                tick();
                cyc++;
                check("stable", 32'(stable), 32'(ref_stable));
                check("gen_count", 32'(gen_count), 32'(ref_gen));
                check("busy_after", 32'(busy), 32'(more));
                if (!more) break;
            end
        end
        run = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check_board();
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        run     = 1'b0;
        disp_ra = 3'd2;
        tb_we   = 1'b0;
        tb_wa   = 3'd0;
        tb_wd   = 8'h00;
        ref_gen = 16'd0;
        ref_stable = 1'b0;
        clear_ref();

        // Reset state.
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_regwrite", 32'(regwrite), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stable", 32'(stable), 32'd0);
        check("rst_gen", 32'(gen_count), 32'd0);
        check("rst_wa", 32'(wa), 32'd0);
        check("rst_wd", 32'(wd), 32'd0);
        check("rst_ra", 32'(ra), 32'd2);
        reset_n = 1'b1;
        tick();

        // Blinker, with idle port sharing and a start poke during SCAN.
        clear_ref();
        ref_b[3] = 8'b00011100;
        load_from_ref();
        disp_ra = 3'd5;
        #1;
        check("idle_ra", 32'(ra), 32'd5);
        check("idle_regwrite", 32'(regwrite), 32'd0);
        check("idle_rd", 32'(rd), 32'(ref_b[5]));
        do_gens(1, 1'b0, 1'b1);
        check("blink_r2", 32'(mem[2]), 32'h08);
        check("blink_r3", 32'(mem[3]), 32'h08);
        check("blink_r4", 32'(mem[4]), 32'h08);
        check("blink_gen", 32'(gen_count), 32'd1);
        check("blink_stable", 32'(stable), 32'd0);
        do_gens(1, 1'b0, 1'b0);
        check("blink_back", 32'(mem[3]), 32'h1C);
        check("blink_back2", 32'(mem[2]), 32'h00);

        // Block still life, single step then run mode.
        clear_ref();
        ref_b[1] = 8'b00011000;
        ref_b[2] = 8'b00011000;
        load_from_ref();
        do_gens(1, 1'b0, 1'b0);
        check("block_stable", 32'(stable), 32'd1);
        do_gens(5, 1'b1, 1'b0);

        // Bottom edge, no wrap.
        clear_ref();
        ref_b[7] = 8'b11100000;
        load_from_ref();
        do_gens(1, 1'b0, 1'b0);
        check("edge_r6", 32'(mem[6]), 32'h40);
        check("edge_r7", 32'(mem[7]), 32'h40);
        check("edge_r0", 32'(mem[0]), 32'h00);

        // Run mode blinker for three generations from a fresh counter.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        ref_gen = 16'd0;
        ref_stable = 1'b0;
        tick();
        clear_ref();
        ref_b[3] = 8'b00011100;
        load_from_ref();
        do_gens(3, 1'b1, 1'b0);
        check("run_gen", 32'(gen_count), 32'd3);

        // Reset during the SCAN row-3 cycle.
        ref_b[3] = 8'b00011100;
        ref_b[2] = 8'h00;
        ref_b[4] = 8'h00;
        load_from_ref();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_regwrite", 32'(regwrite), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_gen", 32'(gen_count), 32'd0);
        check("mid_rst_ra", 32'(ra), 32'(disp_ra));
        compute_next();
        for (int r = 0; r < 3; r++) ref_b[r] = nxt_b[r];
        ref_gen = 16'd0;
        ref_stable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check_board();
        do_gens(1, 1'b0, 1'b0);

        // Random boards, single step.
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < ROWS; r++) ref_b[r] = 8'($urandom);
            disp_ra = 3'($urandom_range(0, 7));
            load_from_ref();
            do_gens(1, 1'b0, 1'b0);
        end

        // Random boards, run mode until stable or a bounded number of gens.
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < ROWS; r++) ref_b[r] = 8'($urandom);
            load_from_ref();
            do_gens(12, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
